tdpr_port_arbiter: RTL and testbench

Round-robin arbiter that shares the two ports of the true dual-port RAM (`True_DPR`, ADDR_SIZE=8, DATA_SIZE=8) among NREQ requesters. Each cycle it grants up to two non-conflicting requests, one on port A and one on port B. It drives the RAM's enable, write-enable, address and data pins directly. It returns read data to the owning requester one cycle after the grant.

---
 rtl/tdpr_port_arbiter_if.sv | 41 ++++
 rtl/tdpr_port_arbiter.sv | 120 ++++++++++++
 tb/tb_tdpr_port_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tdpr_port_arbiter_if.sv
// Requester and RAM-pin bundle for the dual-port RAM arbiter.
// slave = arbiter side, master = requesters plus RAM side.
interface tdpr_port_arbiter_if #(
  parameter int NREQ      = 4,
  parameter int ADDR_SIZE = 8,
  parameter int DATA_SIZE = 8
);
  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0]           req_we;
  logic [NREQ*ADDR_SIZE-1:0] req_addr;
  logic [NREQ*DATA_SIZE-1:0] req_wdata;
  logic [NREQ-1:0]           req_ready;
  logic [NREQ-1:0]           rsp_valid;
  logic [NREQ*DATA_SIZE-1:0] rsp_data;
  logic                      en_a;
  logic                      we_a;
  logic [ADDR_SIZE-1:0]      addr_a;
  logic [DATA_SIZE-1:0]      din_a;
  logic [DATA_SIZE-1:0]      dout_a;
  logic                      en_b;
  logic                      we_b;
  logic [ADDR_SIZE-1:0]      addr_b;
  logic [DATA_SIZE-1:0]      din_b;
  logic [DATA_SIZE-1:0]      dout_b;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    input  dout_a, dout_b,
    output req_ready, rsp_valid, rsp_data,
    output en_a, we_a, addr_a, din_a,
    output en_b, we_b, addr_b, din_b
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    output dout_a, dout_b,
    input  req_ready, rsp_valid, rsp_data,
    input  en_a, we_a, addr_a, din_a,
    input  en_b, we_b, addr_b, din_b
  );
endinterface

// File: rtl/tdpr_port_arbiter.sv
// Round-robin arbiter granting up to two non-conflicting
// requests per cycle onto the A/B ports of a dual-port RAM.
module tdpr_port_arbiter #(
  parameter int NREQ      = 4,
  parameter int ADDR_SIZE = 8,
  parameter int DATA_SIZE = 8
) (
  input logic clk,
  input logic rst_n,
  tdpr_port_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW:0] NR = (PW+1)'(NREQ);

  typedef logic [PW-1:0] idx_t;

  logic [ADDR_SIZE-1:0] addr_v  [NREQ];
  logic [DATA_SIZE-1:0] wdata_v [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_v[g]  = bus.req_addr[g*ADDR_SIZE +: ADDR_SIZE];
    assign wdata_v[g] = bus.req_wdata[g*DATA_SIZE +: DATA_SIZE];
  end

  idx_t ptr;
  idx_t ptr_nxt;
  logic pend_a;
  logic pend_b;
  idx_t idx_a;
  idx_t idx_b;

  logic ga;
  logic gb;
  idx_t wa;
  idx_t wb;
  idx_t cand;

  function automatic idx_t wrap_add(idx_t i, int k);
    logic [PW:0] s;
    s = {1'b0, i} + (PW+1)'(k);
    if (s >= NR) s = s - NR;
    return s[PW-1:0];
  endfunction

  // Scan from ptr; first valid takes A, next non-conflicting takes B.
  always_comb begin
    ga   = 1'b0;
    gb   = 1'b0;
    wa   = '0;
    wb   = '0;
    cand = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = wrap_add(ptr, k);
      if (rst_n && bus.req_valid[cand]) begin
        if (!ga) begin
          ga = 1'b1;
          wa = cand;
        end else if (!gb &&
                     !(addr_v[cand] == addr_v[wa] &&
                       (bus.req_we[cand] || bus.req_we[wa]))) begin
          gb = 1'b1;
          wb = cand;
        end
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (ga) bus.req_ready[wa] = 1'b1;
    if (gb) bus.req_ready[wb] = 1'b1;
  end

  assign bus.en_a   = ga;
  assign bus.we_a   = ga & bus.req_we[wa];
  assign bus.addr_a = ga ? addr_v[wa]  : '0;
  assign bus.din_a  = ga ? wdata_v[wa] : '0;
  assign bus.en_b   = gb;
  assign bus.we_b   = gb & bus.req_we[wb];
  assign bus.addr_b = gb ? addr_v[wb]  : '0;
  assign bus.din_b  = gb ? wdata_v[wb] : '0;

  always_comb begin
    ptr_nxt = ptr;
    if (gb)      ptr_nxt = wrap_add(wb, 1);
    else if (ga) ptr_nxt = wrap_add(wa, 1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr    <= '0;
      pend_a <= 1'b0;
      pend_b <= 1'b0;
      idx_a  <= '0;
      idx_b  <= '0;
    end else begin
      ptr    <= ptr_nxt;
      pend_a <= ga & ~bus.req_we[wa];
      pend_b <= gb & ~bus.req_we[wb];
      idx_a  <= wa;
      idx_b  <= wb;
    end
  end

  // Port A is applied last so it wins if both ever target one requester.
  always_comb begin
    bus.rsp_valid = '0;
    bus.rsp_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (rst_n && pend_b && idx_b == idx_t'(i)) begin
        bus.rsp_valid[i] = 1'b1;
        bus.rsp_data[i*DATA_SIZE +: DATA_SIZE] = bus.dout_b;
      end
      if (rst_n && pend_a && idx_a == idx_t'(i)) begin
        bus.rsp_valid[i] = 1'b1;
        bus.rsp_data[i*DATA_SIZE +: DATA_SIZE] = bus.dout_a;
      end
    end
  end
endmodule

// File: tb/tb_tdpr_port_arbiter.sv
// Bench for tdpr_port_arbiter: behavioural RAM, reference model,
// directed scenarios and randomized protocol-compliant traffic.
module tb_tdpr_port_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tdpr_port_arbiter_if #(.NREQ(N), .ADDR_SIZE(8), .DATA_SIZE(8)) bus();

  tdpr_port_arbiter #(.NREQ(N), .ADDR_SIZE(8), .DATA_SIZE(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural true dual-port RAM with registered read data
  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (bus.en_a) begin
      if (bus.we_a) ram[bus.addr_a] <= bus.din_a;
      else          bus.dout_a <= ram[bus.addr_a];
    end
    if (bus.en_b) begin
      if (bus.we_b) ram[bus.addr_b] <= bus.din_b;
      else          bus.dout_b <= ram[bus.addr_b];
    end
  end

  // Reference model state
  logic [7:0] ref_mem [256];
  int         m_ptr = 0;
  logic [N-1:0] exp_rv = '0;
  logic [7:0]   exp_rd [N];
  logic [N-1:0] xfer = '0;

  function automatic logic [7:0] rq_addr(int i);
    return bus.req_addr[i*8 +: 8];
  endfunction

  function automatic logic [7:0] rq_data(int i);
    return bus.req_wdata[i*8 +: 8];
  endfunction

  always @(negedge clk) begin
    int q[$];
    int pa;
    int pb;
    logic [N-1:0] er;
    logic [N-1:0] nrv;
    logic [7:0]   nrd [N];
    if (!rst_n) begin
      chk("rst_ready", bus.req_ready, 0);
      chk("rst_en", {bus.en_a, bus.en_b, bus.we_a, bus.we_b}, 0);
      chk("rst_addr_din", {bus.addr_a, bus.addr_b, bus.din_a, bus.din_b}, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_data", bus.rsp_data, 0);
      m_ptr  = 0;
      exp_rv = '0;
    end else begin
      q = {};
      for (int k = 0; k < N; k++)
        if (bus.req_valid[(m_ptr + k) % N]) q.push_back((m_ptr + k) % N);
      pa = -1;
      pb = -1;
      if (q.size() > 0) pa = q[0];
      for (int k = 1; k < q.size(); k++)
        if (pb < 0 && !(rq_addr(q[k]) == rq_addr(pa) &&
                        (bus.req_we[q[k]] || bus.req_we[pa])))
          pb = q[k];
      er = '0;
      if (pa >= 0) er[pa] = 1'b1;
      if (pb >= 0) er[pb] = 1'b1;
      chk("ready", bus.req_ready, er);
      chk("en_a", bus.en_a, pa >= 0);
      chk("en_b", bus.en_b, pb >= 0);
      chk("port_a",
          {bus.we_a, bus.addr_a, bus.din_a},
          pa >= 0 ? {bus.req_we[pa], rq_addr(pa), rq_data(pa)} : 17'd0);
      chk("port_b",
          {bus.we_b, bus.addr_b, bus.din_b},
          pb >= 0 ? {bus.req_we[pb], rq_addr(pb), rq_data(pb)} : 17'd0);
      chk("rsp_valid", bus.rsp_valid, exp_rv);
      for (int i = 0; i < N; i++)
        if (exp_rv[i]) chk($sformatf("rsp_data%0d", i),
                           bus.rsp_data[i*8 +: 8], exp_rd[i]);
      nrv = '0;
      for (int i = 0; i < N; i++) nrd[i] = 8'h00;
      if (pa >= 0 && !bus.req_we[pa]) begin
        nrv[pa] = 1'b1;
        nrd[pa] = ref_mem[rq_addr(pa)];
      end
      if (pb >= 0 && !bus.req_we[pb]) begin
        nrv[pb] = 1'b1;
        nrd[pb] = ref_mem[rq_addr(pb)];
      end
      if (pa >= 0 && bus.req_we[pa]) ref_mem[rq_addr(pa)] = rq_data(pa);
      if (pb >= 0 && bus.req_we[pb]) ref_mem[rq_addr(pb)] = rq_data(pb);
      if (pb >= 0)      m_ptr = (pb + 1) % N;
      else if (pa >= 0) m_ptr = (pa + 1) % N;
      exp_rv = nrv;
      for (int i = 0; i < N; i++) exp_rd[i] = nrd[i];
    end
    xfer = bus.req_ready & bus.req_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int i, logic w, logic [7:0] a, logic [7:0] d);
    bus.req_valid[i]       = 1'b1;
    bus.req_we[i]          = w;
    bus.req_addr[i*8 +: 8] = a;
    bus.req_wdata[i*8 +: 8] = d;
  endtask

  task automatic clr();
    bus.req_valid = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]     = 8'h00;
      ref_mem[i] = 8'h00;
    end
    for (int i = 0; i < N; i++) exp_rd[i] = 8'h00;
    bus.dout_a    = 8'h00;
    bus.dout_b    = 8'h00;
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'(8'h40 + i), 8'h00);

    // Reset held with all requesters valid
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("d_rst_ready", bus.req_ready, 4'b0000);
      chk("d_rst_en", {bus.en_a, bus.en_b}, 2'b00);
      chk("d_rst_rsp", bus.rsp_valid, 4'b0000);
    end
    rst_n = 1'b1;
    #1 chk("d_release", bus.req_ready, 4'b0011);
    tick();
    clr();

    // Parallel writes then reads
    do_reset();
    set_req(0, 1'b1, 8'h01, 8'hA1);
    set_req(2, 1'b1, 8'h10, 8'hBB);
    #1 chk("d_pw_ready", bus.req_ready, 4'b0101);
    chk("d_pw_addr", {bus.addr_a, bus.addr_b}, 16'h0110);
    tick();
    clr();
    set_req(1, 1'b0, 8'h01, 8'h00);
    set_req(3, 1'b0, 8'h10, 8'h00);
    #1 chk("d_pr_ready", bus.req_ready, 4'b1010);
    tick();
    clr();
    #1 chk("d_pr_valid", bus.rsp_valid, 4'b1010);
    chk("d_pr_data1", bus.rsp_data[15:8], 8'hA1);
    chk("d_pr_data3", bus.rsp_data[31:24], 8'hBB);

    // Write-write conflict
    do_reset();
    set_req(0, 1'b1, 8'h11, 8'h16);
    set_req(1, 1'b1, 8'h11, 8'h22);
    #1 chk("d_ww_first", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid[0] = 1'b0;
    #1 chk("d_ww_second", bus.req_ready, 4'b0010);
    tick();
    clr();
    set_req(2, 1'b0, 8'h11, 8'h00);
    #1 chk("d_ww_rd_ready", bus.req_ready, 4'b0100);
    tick();
    clr();
    #1 chk("d_ww_rd_valid", bus.rsp_valid, 4'b0100);
    chk("d_ww_rd_data", bus.rsp_data[23:16], 8'h22);

    // Read-write conflict, then read-read share
    do_reset();
    set_req(0, 1'b0, 8'h20, 8'h00);
    set_req(1, 1'b1, 8'h20, 8'h77);
    #1 chk("d_rw_first", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid[0] = 1'b0;
    #1 chk("d_rw_second", bus.req_ready, 4'b0010);
    tick();
    clr();
    set_req(0, 1'b1, 8'h30, 8'h5C);
    #1 chk("d_rr_fill", bus.req_ready, 4'b0001);
    tick();
    clr();
    set_req(0, 1'b0, 8'h30, 8'h00);
    set_req(1, 1'b0, 8'h30, 8'h00);
    #1 chk("d_rr_ready", bus.req_ready, 4'b0011);
    tick();
    clr();
    #1 chk("d_rr_valid", bus.rsp_valid, 4'b0011);
    chk("d_rr_data", bus.rsp_data[15:0], 16'h5C5C);

    // Fairness and pointer wrap
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'(8'h40 + i), 8'h00);
    for (int c = 0; c < 6; c++) begin
      #1 chk("d_fair", bus.req_ready, (c % 2) ? 4'b1100 : 4'b0011);
      tick();
    end
    clr();

    // Reset mid-read discards the response
    do_reset();
    set_req(2, 1'b0, 8'h01, 8'h00);
    #1 chk("d_mr_ready", bus.req_ready, 4'b0100);
    tick();
    clr();
    rst_n = 1'b0;
    #1 chk("d_mr_rsp0", bus.rsp_valid, 4'b0000);
    tick();
    chk("d_mr_rsp1", bus.rsp_valid, 4'b0000);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'(8'h50 + i), 8'h00);
    #1 chk("d_mr_ptr0", bus.req_ready, 4'b0011);
    tick();
    clr();

    // Randomized protocol-compliant traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst_n = ($urandom_range(0, 99) != 0);
      for (int i = 0; i < N; i++) begin
        if (bus.req_valid[i] && xfer[i]) bus.req_valid[i] = 1'b0;
        if (!bus.req_valid[i] && $urandom_range(0, 9) < 6)
          set_req(i, 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 7)), 8'($urandom));
      end
    end
    tick();
    clr();
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
